// File: rtl/nios_system_switch_pio_irq.sv
// Avalon-MM input PIO for board switches and keys: per-bit synchroniser, debounce,
// edge capture and a maskable level interrupt. Read data is registered (1-cycle latency).
module nios_system_switch_pio_irq #(
   parameter int               WIDTH           = 18,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CNT_W-1:0] cnt    [WIDTH];
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] debounced_d;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] clear_bits;
   logic [WIDTH-1:0] rd_mux;
   logic             mask_wr;
   logic [31:0]      unused_writedata;

   assign unused_writedata = writedata;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign raw = sync_q[SYNC_STAGES-1];

   // NOTE: the per-bit counter array is reset like any flop so an aborted count never resumes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         debounced <= RESET_VALUE;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (raw[i] == debounced[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               debounced[i] <= raw[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      // NOTE: defaults come first so no path through a combinational block infers a latch.
      edge_det = '0;
      case (EDGE_TYPE)
         0:       edge_det = debounced & ~debounced_d;
         1:       edge_det = ~debounced & debounced_d;
         default: edge_det = debounced ^ debounced_d;
      endcase
   end

   assign clear_bits = (chipselect && write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
   assign mask_wr    = chipselect && write && address == 2'd1;

   // A new edge is OR-ed in after the clear, so a same-cycle set beats write-1-clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         debounced_d <= RESET_VALUE;
         edgecapture <= '0;
         irq_mask    <= '0;
      end else begin
         debounced_d <= debounced;
         edgecapture <= (edgecapture & ~clear_bits) | edge_det;
         if (mask_wr) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = debounced;
         2'd1:    rd_mux = irq_mask;
         2'd2:    rd_mux = edgecapture;
         default: rd_mux = raw;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= 32'(rd_mux);
   end

   assign irq = |(edgecapture & irq_mask);

endmodule

// File: tb/tb_nios_system_switch_pio_irq.sv
// Self-checking bench for nios_system_switch_pio_irq: directed scenarios plus random
// stimulus, every cycle compared against a window-based behavioural model.
module tb_nios_system_switch_pio_irq;
   localparam int               WIDTH           = 4;
   localparam int               SYNC_STAGES     = 2;
   localparam int               DEBOUNCE_CYCLES = 4;
   localparam int               EDGE_TYPE       = 0;
   localparam logic [WIDTH-1:0] RESET_VALUE     = '0;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       address;
   logic             chipselect;
   logic             write;
   logic [31:0]      writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0]      readdata;
   logic             irq;

   always #5 clk = ~clk;

   nios_system_switch_pio_irq #(
      .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE(EDGE_TYPE), .RESET_VALUE(RESET_VALUE)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write(write), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: raw is in_port delayed through a queue; a debounced bit flips once the last
   // DEBOUNCE_CYCLES raw samples all disagree with it.
   logic [WIDTH-1:0] in_q  [$];
   logic [WIDTH-1:0] raw_q [$];
   logic [WIDTH-1:0] m_raw, m_deb, m_deb_prev, m_ec, m_mask;
   logic [31:0]      m_rd;

   function automatic logic m_irq();
      return |(m_ec & m_mask);
   endfunction

   task automatic model_reset();
      in_q.delete();
      raw_q.delete();
      for (int s = 0; s < SYNC_STAGES - 1; s++) in_q.push_back(RESET_VALUE);
      for (int j = 0; j < DEBOUNCE_CYCLES; j++) raw_q.push_back(RESET_VALUE);
      m_raw = RESET_VALUE; m_deb = RESET_VALUE; m_deb_prev = RESET_VALUE;
      m_ec = '0; m_mask = '0; m_rd = '0;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] raw_pre, deb_pre, prev_pre, ec_pre, clr, ev;
      logic             stable;
      raw_pre = m_raw; deb_pre = m_deb; prev_pre = m_deb_prev; ec_pre = m_ec;
      case (address)
         2'd0:    m_rd = 32'(deb_pre);
         2'd1:    m_rd = 32'(m_mask);
         2'd2:    m_rd = 32'(ec_pre);
         default: m_rd = 32'(raw_pre);
      endcase
      in_q.push_back(in_port);
      m_raw = in_q.pop_front();
      raw_q.push_back(raw_pre);
      raw_q.delete(0);
      for (int b = 0; b < WIDTH; b++) begin
         stable = 1'b1;
         foreach (raw_q[j]) if (raw_q[j][b] == deb_pre[b]) stable = 1'b0;
         if (stable) m_deb[b] = ~deb_pre[b];
      end
      case (EDGE_TYPE)
         0:       ev = deb_pre & ~prev_pre;
         1:       ev = ~deb_pre & prev_pre;
         default: ev = deb_pre ^ prev_pre;
      endcase
      m_deb_prev = deb_pre;
      clr  = (chipselect && write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
      m_ec = (ec_pre & ~clr) | ev;
      if (chipselect && write && address == 2'd1) m_mask = writedata[WIDTH-1:0];
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (!reset) model_step();
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(m_irq()));
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      address = a; chipselect = 1'b1; write = 1'b0;
      cycle();
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
      cycle();
      chipselect = 1'b0; write = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [3:0]  seen;
      bit          found;

      reset = 1'b1; address = '0; chipselect = 1'b0; write = 1'b0;
      writedata = '0; in_port = '0;
      model_reset();
      #1;
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      repeat (2) cycle();
      reset = 1'b0;

      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), rd);
         check("rst_read", rd, 32'h0);
      end

      // Glitch of 3 cycles on bit0: visible on raw, filtered from data and edgecapture.
      seen = '0;
      address = 2'd3;
      in_port = 4'h1;
      repeat (3) begin cycle(); seen |= readdata[3:0]; end
      in_port = 4'h0;
      repeat (8) begin cycle(); seen |= readdata[3:0]; end
      check("glitch_raw_seen", 32'(seen), 32'h1);
      read_reg(2'd0, rd); check("glitch_data", rd, 32'h0);
      read_reg(2'd2, rd); check("glitch_edge", rd, 32'h0);

      write_reg(2'd1, 32'hFFFF_FFF1);
      read_reg(2'd1, rd); check("mask_upper_ignored", rd, 32'h1);

      in_port = 4'h5;
      for (int i = 0; i < 10; i++) begin
         address = 2'(i % 4);
         cycle();
      end
      read_reg(2'd0, rd); check("data_5", rd, 32'h5);
      read_reg(2'd3, rd); check("raw_5", rd, 32'h5);
      read_reg(2'd2, rd); check("edge_5", rd, 32'h5);
      check("irq_set", 32'(irq), 32'h1);

      write_reg(2'd2, 32'h1);
      check("irq_cleared", 32'(irq), 32'h0);
      read_reg(2'd2, rd); check("edge_after_clr", rd, 32'h4);
      write_reg(2'd0, 32'hF);
      read_reg(2'd0, rd); check("data_write_ignored", rd, 32'h5);

      // Drop bit0, clear everything, then collide its next rising edge with a clear.
      in_port = 4'h4;
      repeat (10) cycle();
      write_reg(2'd2, 32'hF);
      in_port = 4'h5;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         cycle();
         if (m_deb[0] && !m_deb_prev[0]) found = 1'b1;
      end
      check("wait_rise_bit0", 32'(found), 32'h1);
      write_reg(2'd2, 32'h1);
      check("set_wins_irq", 32'(irq), 32'h1);
      read_reg(2'd2, rd); check("set_wins_edge", rd, 32'h1);

      // Reset in the middle of a debounce count.
      in_port = 4'h0;
      repeat (12) cycle();
      in_port = 4'hF;
      repeat (3) cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check("midrst_readdata", readdata, 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);
      repeat (2) cycle();
      reset = 1'b0;
      address = 2'd0;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         check("release_data", readdata, (k >= 7) ? 32'hF : 32'h0);
      end
      read_reg(2'd1, rd); check("mask_after_rst", rd, 32'h0);
      read_reg(2'd2, rd); check("edge_after_rst", rd, 32'hF);
      write_reg(2'd1, 32'h8);
      check("unmask_irq", 32'(irq), 32'h1);

      for (int i = 0; i < 800; i++) begin
         for (int b = 0; b < WIDTH; b++)
            if ($urandom_range(0, 11) == 0) in_port[b] = ~in_port[b];
         address    = 2'($urandom_range(0, 3));
         chipselect = 1'($urandom_range(0, 1));
         write      = ($urandom_range(0, 5) == 0);
         writedata  = $urandom();
         if (i == 400) begin
            reset = 1'b1;
            model_reset();
         end
         if (i == 403) reset = 1'b0;
         cycle();
      end
      chipselect = 1'b0;
      write = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
